fpu_mult_requester: RTL

Initiator side of the floating-point multiplier handshake. Accepts IEEE-754 single-precision operand pairs on a valid/ready stream and issues them one at a time to the multiplier over its `initiate` / `ready_mult_out` interface. Collects each product, with an overflow code and a timeout error flag, and presents it on an output valid/ready stream. It sits between the filter-matrix operand sequencer and the multiplier, so the sequencer never deals with multiplier timing.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_mult_requester.sv | 106 ++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point multiplier handshake blocks.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  // Requester FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } req_state_t;

  // Exponent overflow codes reported by the multiplier
  localparam logic [2:0] OVF_NONE = 3'd0;
  localparam logic [2:0] OVF_HIGH = 3'd1;
  localparam logic [2:0] OVF_LOW  = 3'd2;

  // IEEE-754 single-precision field widths
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;
  localparam int FP_W      = 1 + FP_EXP_W + FP_MANT_W;

endpackage

// File: rtl/fpu_mult_requester.sv
// Issues operand pairs to the FP multiplier one at a time and returns the product.
// Latency: accept to m_valid = BLANK+3 cycles with a 2-cycle multiplier, TIMEOUT+3 on timeout.
// Backpressure: s_ready only in IDLE; result held stable in HOLD until m_ready.
module fpu_mult_requester
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int BLANK   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FP_W-1:0]   s_a,
  input  logic [FP_W-1:0]   s_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FP_W-1:0]   m_result,
  output logic [2:0]        m_ovf,
  output logic              m_error,
  output logic [FP_W-1:0]   mult_a,
  output logic [FP_W-1:0]   mult_b,
  output logic              mult_initiate,
  input  logic              mult_ready,
  input  logic [FP_W-1:0]   mult_result,
  input  logic [2:0]        mult_ovf,
  output logic              busy,
  output logic [CNT_W-1:0]  done_count
);

  // The counter must be able to reach TIMEOUT itself, hence the +1.
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] BLANK_C   = WCNT_W'(BLANK);
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

  req_state_t        state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              rdy_hit;
  logic              tmo_hit;

  // Handshake outputs decode straight from the registered state.
  assign s_ready       = (state == ST_IDLE);
  assign mult_initiate = (state == ST_ISSUE);
  assign m_valid       = (state == ST_HOLD);
  assign busy          = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a real ready beats the timeout in the same cycle
  always_comb begin
    state_nxt = state;
    rdy_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:  if (s_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // Ready is blanked right after issue: the level may still be
        // high from the previous product.
        if ((wait_cnt >= BLANK_C) && mult_ready) begin
          rdy_hit   = 1'b1;
          state_nxt = ST_HOLD;
        end else if (wait_cnt == TIMEOUT_C) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD:  if (m_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, wait counter, result capture and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a     <= '0;
      mult_b     <= '0;
      wait_cnt   <= '0;
      m_result   <= '0;
      m_ovf      <= OVF_NONE;
      m_error    <= 1'b0;
      done_count <= '0;
    end else begin
      if ((state == ST_IDLE) && s_valid) begin
        mult_a <= s_a;
        mult_b <= s_b;
      end
      if (state == ST_ISSUE) wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      // On timeout the product is captured anyway so overflow paths that
      // never raise ready still report their code.
      if (rdy_hit || tmo_hit) begin
        m_result <= mult_result;
        m_ovf    <= mult_ovf;
        m_error  <= tmo_hit;
      end
      if ((state == ST_HOLD) && m_ready) done_count <= done_count + 1'b1;
    end
  end

endmodule
